// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared FSM encoding, RGB565-to-RGB444 field positions and address width
package ov7670_pkg;
  localparam int ADDR_W = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_VSYNC, ST_ACTIVE} state_t;
  localparam int R_MSB = 7;
  localparam int R_LSB = 4;
  localparam int G_HI_MSB = 2;
  localparam int G_LO_BIT = 7;
  localparam int B_MSB = 4;
  localparam int B_LSB = 1;
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[R_MSB:R_LSB], hi[G_HI_MSB:0], lo[G_LO_BIT], lo[B_MSB:B_LSB]};
  endfunction
endpackage

// File: rtl/cam_input_sync.sv
// cam_input_sync: multi-flop synchroniser for the DVP bus with pclk/vsync/href edge detection
module cam_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_s,
  output logic       href_fall,
  output logic [7:0] data_s
);
  logic [SYNC_STAGES-1:0][10:0] stg;
  logic pclk_s, vsync_s, pclk_q, vsync_q, href_q;
  always_ff @(posedge clk) begin
    stg <= rst ? '0 : {stg[SYNC_STAGES-2:0], {pclk, vsync, href, data}};
    {pclk_q, vsync_q, href_q} <= rst ? 3'b000 : stg[SYNC_STAGES-1][10:8];
  end
  assign {pclk_s, vsync_s, href_s, data_s} = stg[SYNC_STAGES-1];
  assign pclk_rise = pclk_s & ~pclk_q;
  assign vsync_rise = vsync_s & ~vsync_q;
  assign vsync_fall = ~vsync_s & vsync_q;
  assign href_fall = ~href_s & href_q;
endmodule

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: DVP byte-pair assembly into RGB444 pixels with frame-relative write addresses
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cam_pclk,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  input  logic              i_capture_en,
  output logic [ADDR_W-1:0] o_h_addr,
  output logic [ADDR_W-1:0] o_v_addr,
  output logic              o_valid,
  output logic [11:0]       o_pixel_data,
  output logic              o_frame_done,
  output logic              o_line_err
);
  localparam logic [ADDR_W-1:0] H_MAX = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_MAX = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] CNT_SAT = '1;
  logic pclk_rise, vsync_rise, vsync_fall, href_s, href_fall;
  logic [7:0] data_s, b0;
  state_t state, state_nx;
  logic cap_on, phase, emitted;
  logic [ADDR_W-1:0] h_cnt, v_cnt;
  logic active, frame_start, frame_end, take, emit, line_end;
  cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(i_clk),
    .rst(i_rst),
    .pclk(i_cam_pclk),
    .vsync(i_cam_vsync),
    .href(i_cam_href),
    .data(i_cam_data),
    .pclk_rise(pclk_rise),
    .vsync_rise(vsync_rise),
    .vsync_fall(vsync_fall),
    .href_s(href_s),
    .href_fall(href_fall),
    .data_s(data_s)
  );
  always_ff @(posedge i_clk) state <= i_rst ? ST_IDLE : state_nx;
  always_comb begin
    active = state == ST_ACTIVE;
    frame_start = state == ST_VSYNC && vsync_fall;
    frame_end = active && vsync_rise;
    take = active && pclk_rise && href_s;
    emit = take && phase && cap_on && h_cnt < H_MAX && v_cnt < V_MAX;
    line_end = active && href_fall;
    state_nx = (state == ST_IDLE && vsync_rise) || frame_end ? ST_VSYNC : frame_start ? ST_ACTIVE : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {cap_on, phase, emitted, o_valid, o_frame_done, o_line_err} <= '0;
      b0 <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      o_h_addr <= '0;
      o_v_addr <= '0;
      o_pixel_data <= '0;
    end else begin
      o_valid <= emit;
      o_frame_done <= frame_end && cap_on && (emitted || emit);
      o_line_err <= line_end && (phase || h_cnt > H_MAX);
      if (emit) begin
        o_h_addr <= h_cnt;
        o_v_addr <= v_cnt;
        o_pixel_data <= rgb565_to_444(b0, data_s);
        emitted <= 1'b1;
      end
      if (take) begin
        if (!phase) b0 <= data_s;
        phase <= ~phase;
        if (phase && h_cnt != CNT_SAT) h_cnt <= h_cnt + ADDR_W'(1);
      end
      if (line_end) begin
        h_cnt <= '0;
        phase <= 1'b0;
        if (v_cnt != CNT_SAT) v_cnt <= v_cnt + ADDR_W'(1);
      end
      if (frame_start) begin
        cap_on <= i_capture_en;
        emitted <= 1'b0;
        h_cnt <= '0;
        v_cnt <= '0;
        phase <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture: table-driven and randomized check of pixel capture against a line-level model
module tb_ov7670_pixel_capture;
  localparam int H = 640;
  localparam int V = 480;
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] pix;
    int          h;
    int          v;
  } vec_t;
  logic clk = 0, rst = 1, pclk = 0, vsync = 0, href = 0, en = 0;
  logic [7:0] data = 0;
  logic [9:0] h_addr, v_addr;
  logic [11:0] pix;
  logic valid, frame_done, line_err;
  int checks = 0, fails = 0, cyc = 0, rise_cyc = 0;
  int err_cnt = 0, done_cnt = 0, valid_cnt = 0, exp_err = 0, exp_done = 0;
  int cur_emits = 0, cur_row = 0, vb = 0;
  bit in_frame = 0, cur_cap = 0, prev_valid = 0;
  int eh[$], ev[$], ep[$];
  logic [7:0] lb[$];

  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cam_pclk(pclk),
    .i_cam_vsync(vsync),
    .i_cam_href(href),
    .i_cam_data(data),
    .i_capture_en(en),
    .o_h_addr(h_addr),
    .o_v_addr(v_addr),
    .o_valid(valid),
    .o_pixel_data(pix),
    .o_frame_done(frame_done),
    .o_line_err(line_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic int px(input int b0, input int b1);
    int r5 = b0 >> 3;
    int g6 = ((b0 & 7) << 3) | (b1 >> 5);
    int b5 = b1 & 31;
    return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
  endfunction

  always @(posedge clk) begin
    #1;
    if (line_err) err_cnt++;
    if (frame_done) done_cnt++;
    if (valid) begin
      valid_cnt++;
      chk("valid_width", int'(prev_valid), 0);
      chk("valid_latency", cyc - rise_cyc, 3);
      if (ep.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid h=%0d v=%0d pix=%h expected no pixel", h_addr, v_addr, pix);
      end else begin
        chk("h_addr", int'(h_addr), eh.pop_front());
        chk("v_addr", int'(v_addr), ev.pop_front());
        chk("pixel", int'(pix), ep.pop_front());
      end
    end
    prev_valid = valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cam_byte(input logic [7:0] b, input logic h);
    pclk = 0;
    href = h;
    data = b;
    repeat (2) @(negedge clk);
    pclk = 1;
    rise_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic vsync_pulse(input bit e);
    if (in_frame && cur_cap && cur_emits > 0) exp_done++;
    en = e;
    vsync = 1;
    cam_byte(0, 0);
    cam_byte(0, 0);
    vsync = 0;
    cam_byte(0, 0);
    cam_byte(0, 0);
    in_frame = 1;
    cur_cap = e;
    cur_emits = 0;
    cur_row = 0;
  endtask

  task automatic model_line();
    int np = lb.size() / 2;
    if (!in_frame || lb.size() == 0) return;
    for (int k = 0; k < np; k++)
      if (cur_cap && k < H && cur_row < V) begin
        eh.push_back(k);
        ev.push_back(cur_row);
        ep.push_back(px(lb[2*k], lb[2*k+1]));
        cur_emits++;
      end
    if (lb.size() % 2 == 1 || np > H) exp_err++;
    cur_row++;
  endtask

  task automatic drive_line();
    foreach (lb[i]) cam_byte(lb[i], 1);
    cam_byte(0, 0);
    cam_byte(0, 0);
  endtask

  task automatic send_line();
    model_line();
    drive_line();
  endtask

  task automatic rand_line(input int n);
    lb.delete();
    repeat (n) lb.push_back(8'($urandom));
  endtask

  task automatic checkpoint(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, "_drained"}, ep.size(), 0);
    chk({tag, "_line_err"}, err_cnt, exp_err);
    chk({tag, "_frame_done"}, done_cnt, exp_done);
    eh.delete();
    ev.delete();
    ep.delete();
    err_cnt = exp_err;
    done_cnt = exp_done;
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{8'hF8, 8'h00, 12'hF00, 0, 0};
    tbl[1] = '{8'h07, 8'hE0, 12'h0F0, 1, 0};
    tbl[2] = '{8'h00, 8'h1F, 12'h00F, 0, 1};
    tbl[3] = '{8'hFF, 8'hFF, 12'hFFF, 1, 1};
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_h_addr", int'(h_addr), 0);
    chk("rst_v_addr", int'(v_addr), 0);
    chk("rst_pixel", int'(pix), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_line_err", int'(line_err), 0);
    rst = 0;
    vsync_pulse(1);
    vb = valid_cnt;
    for (int r = 0; r < 2; r++) begin
      lb = {tbl[2*r].b0, tbl[2*r].b1, tbl[2*r+1].b0, tbl[2*r+1].b1};
      for (int j = 2 * r; j < 2 * r + 2; j++) begin
        eh.push_back(tbl[j].h);
        ev.push_back(tbl[j].v);
        ep.push_back(tbl[j].pix);
      end
      cur_emits += 2;
      cur_row++;
      drive_line();
    end
    vsync_pulse(1);
    checkpoint("table_2x2");
    chk("table_valid_count", valid_cnt - vb, 4);
    vb = valid_cnt;
    rand_line(2 * (H + 1));
    send_line();
    checkpoint("overlong_line");
    chk("overlong_valid_count", valid_cnt - vb, H);
    vb = valid_cnt;
    rand_line(5);
    send_line();
    rand_line(4);
    send_line();
    checkpoint("odd_line");
    chk("odd_valid_count", valid_cnt - vb, 4);
    vsync_pulse(0);
    en = 1;
    vb = valid_cnt;
    rand_line(8);
    send_line();
    rand_line(6);
    send_line();
    vsync_pulse(1);
    chk("cap_off_valid_count", valid_cnt - vb, 0);
    rand_line(6);
    send_line();
    rand_line(6);
    send_line();
    vsync_pulse(1);
    checkpoint("capture_en");
    for (int r = 0; r < 5; r++) begin
      rand_line(4);
      send_line();
    end
    rand_line(200);
    model_line();
    foreach (lb[i]) cam_byte(lb[i], 1);
    repeat (4) @(negedge clk);
    rst = 1;
    in_frame = 0;
    cur_cap = 0;
    cam_byte(8'($urandom), 1);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_h_addr", int'(h_addr), 0);
    chk("midrst_v_addr", int'(v_addr), 0);
    chk("midrst_pixel", int'(pix), 0);
    cam_byte(8'($urandom), 1);
    rst = 0;
    vb = valid_cnt;
    repeat (4) cam_byte(8'($urandom), 1);
    cam_byte(0, 0);
    cam_byte(0, 0);
    chk("no_valid_after_reset", valid_cnt - vb, 0);
    checkpoint("reset_midline");
    vsync_pulse(1);
    rand_line(4);
    send_line();
    checkpoint("after_reset");
    repeat (4) begin
      vsync_pulse($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 4)) begin
        rand_line($urandom_range(0, 11));
        send_line();
      end
    end
    vsync_pulse(1);
    checkpoint("random_frames");
    vb = valid_cnt;
    for (int r = 0; r <= V; r++) begin
      rand_line(r == V - 1 ? 2 * H : 4);
      send_line();
    end
    checkpoint("full_height");
    chk("full_valid_count", valid_cnt - vb, (V - 1) * 2 + H);
    chk("final_h_addr", int'(h_addr), H - 1);
    chk("final_v_addr", int'(v_addr), V - 1);
    vsync_pulse(1);
    checkpoint("full_height_done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Upstream stage of the VGA BRAM interface. Samples the raw OV7670 DVP bus (PCLK, VSYNC, HREF, D[7:0]) in the system clock domain.
- Assembles RGB565 byte pairs into 12-bit RGB444 pixels and generates the frame-relative h/v write address with a one-cycle valid strobe.
- Outputs connect directly to the interface's i_h_addr, i_v_addr, i_valid and i_pixel_data.

Parameters:
- H_ACTIVE, 640, pixels per line accepted; pixels beyond this are dropped.
- V_ACTIVE, 480, lines per frame accepted; lines beyond this are dropped.
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on every camera input (minimum 2).

Ports:
- i_clk  input  1  system clock; must be at least 4x the camera PCLK frequency.
- i_rst  input  1  synchronous, active-high reset.
- i_cam_pclk  input  1  camera pixel clock, treated as data.
- i_cam_vsync  input  1  camera VSYNC, active-high pulse at frame boundary.
- i_cam_href  input  1  camera HREF, high during active line bytes.
- i_cam_data  input  8  camera data byte.
- i_capture_en  input  1  enable capture; sampled only at frame start.
- o_h_addr  output  10  pixel column, 0..H_ACTIVE-1.
- o_v_addr  output  10  pixel row, 0..V_ACTIVE-1.
- o_valid  output  1  one-i_clk pulse; pixel and address are valid.
- o_pixel_data  output  12  {R4,G4,B4}.
- o_frame_done  output  1  one-cycle pulse at end of a captured frame.
- o_line_err  output  1  one-cycle pulse on an odd byte count or an overlong line.

Behaviour:
- Reset: all outputs are 0, the FSM is in ST_IDLE, counters are 0, byte phase is 0 and the synchronisers are cleared.
- Reset is synchronous and active-high. Asserting it mid-frame abandons the frame; no output is produced until the next VSYNC fall.
- Synchronisers: pclk, vsync, href and data each pass through SYNC_STAGES flops.
  - pclk_rise = synced pclk is 1 and its previous value was 0.
  - All sampling happens only in pclk_rise cycles, using the synced href and data from that same cycle.
- VSYNC rise and fall are detected from the synced vsync.
- FSM states and transitions:
  - ST_IDLE: on a vsync rise, go to ST_VSYNC.
  - ST_VSYNC: on a vsync fall, latch i_capture_en into cap_on and go to ST_ACTIVE. Clear v_cnt, h_cnt and byte phase.
  - ST_ACTIVE: on a vsync rise, pulse o_frame_done if cap_on is 1 and at least one pixel was emitted, then go to ST_VSYNC.
- Byte assembly, in ST_ACTIVE with pclk_rise and href high:
  - Phase 0: store byte b0 and set phase to 1.
  - Phase 1: form the pixel R = b0[7:4], G = {b0[2:0], d[7]}, B = d[4:1], then set phase to 0.
- Pixel emission (phase 1 completion):
  - If cap_on, h_cnt < H_ACTIVE and v_cnt < V_ACTIVE: o_valid = 1 in the next i_clk cycle, with o_pixel_data, o_h_addr = h_cnt and o_v_addr = v_cnt registered together.
  - h_cnt increments whether or not the pixel is emitted, and saturates at 1023.
- Latency: o_valid rises exactly 1 i_clk after the pclk_rise cycle that captures the second byte, and is high for exactly 1 cycle.
  - o_h_addr, o_v_addr and o_pixel_data hold their last values while o_valid is 0.
- Line end is the synced href falling edge in ST_ACTIVE. On line end:
  - v_cnt increments, saturating at 1023.
  - h_cnt is cleared to 0.
  - If phase was 1, the partial byte is discarded, phase is set to 0 and o_line_err pulses.
  - If h_cnt > H_ACTIVE, o_line_err pulses. The two conditions produce a single pulse.
- A vsync rise in the same cycle as an href fall: line-end handling is applied first, then the FSM transition, both in the same cycle.
- Deasserting i_capture_en mid-frame has no effect until the next frame start.
- href high outside ST_ACTIVE is ignored.

Decomposition:
- Package ov7670_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_VSYNC, ST_ACTIVE);
  - RGB565-to-RGB444 bit-field constants;
  - the address width of 10.
- One natural sub-module, cam_input_sync: the parameterised SYNC_STAGES synchroniser plus pclk rise and vsync rise/fall detectors. It is instantiated once and covers the 11 input bits.

Test Plan:
- Reset asserted mid-line at pixel 100 of row 5, then released -> no o_valid until the next vsync fall; the first pixel then has h=0, v=0.
- One frame of 2x2 pixels, bytes (0xF8,0x00),(0x07,0xE0),(0x00,0x1F),(0xFF,0xFF), with PCLK = i_clk/4 -> o_pixel_data F00,0F0,00F,FFF; addresses (0,0),(1,0),(0,1),(1,1); each o_valid exactly 1 cycle, 1 cycle after the second-byte pclk_rise; o_frame_done pulses once on the next vsync rise.
- Line of 641 pixels with H_ACTIVE=640 -> 640 o_valid pulses, h 0..639; pixel 641 suppressed; o_line_err pulses once at href fall.
- Line with 5 bytes (odd count) -> 2 pixels emitted; o_line_err pulses at href fall; next line starts at h=0, phase 0.
- i_capture_en=0 at vsync fall, raised mid-frame -> zero o_valid and no o_frame_done for that frame; the next frame is captured fully.
- Full 640x480 frame at PCLK = i_clk/4 -> exactly 307200 o_valid pulses; the final address is (639,479).
